instr_decode_pipe: RTL and testbench
====================================

INSTR_DECODE_PIPE -- requirements
Module: instr_decode_pipe

Interface
REQ-001 SHALL have parameter INSTR_W, default 17: instruction width; must satisfy INSTR_W >= OP_W + 3*REG_W.
REQ-002 SHALL have parameter OP_W, default 5: opcode width, taken from field [INSTR_W-1 -: OP_W].
REQ-003 SHALL have parameter REG_W, default 3: register-address width; fields below the opcode are, in order, DA, AA, BA, each REG_W wide.
REQ-004 SHALL have parameter CNT_W, default 16: bubble-counter width.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1 bit: instruction offered.
REQ-008 SHALL have port in_ready, output, 1 bit: instruction can be accepted.
REQ-009 SHALL have port instr, input, INSTR_W bits: instruction word.
REQ-010 SHALL have port flush, input, 1 bit: discard all held and registered work.
REQ-011 SHALL have port out_valid, output, 1 bit: control word valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the control word.
REQ-013 SHALL have the following control-word outputs, all registered: RW, PS, MW, MA, MB, CS, fpga_wrt (1 bit each); MD, BS (2 bits each); FS (4 bits); DA, AA, BA (REG_W bits each).
REQ-014 SHALL have port illegal, output, 1 bit: registered word came from an undefined opcode.
REQ-015 SHALL have port bubble, output, 1 bit: registered word is an inserted interlock NOP.
REQ-016 SHALL have port bubble_cnt, output, CNT_W bits: count of bubbles issued.

Function
REQ-017 SHALL decode every field, including fpga_wrt, for every opcode, with no inferred latches; any field the ISA table leaves unspecified takes its NOP value.
REQ-018 SHALL, for undefined opcodes (0x10, and 0x16 through 2^OP_W-1), emit NOP controls with illegal=1.
REQ-019 SHALL define the NOP control word as: FS=4'b1001, all other controls 0, DA=AA=BA=0.
REQ-020 SHALL implement a three-state FSM with states EMPTY (out_valid=0), FULL (out_valid=1) and HOLD (out_valid=1, bubble shown, pending instruction in the hold register).
REQ-021 SHALL drive in_ready = !flush && state!=HOLD && (!out_valid || out_ready).
REQ-022 SHALL define accept as in_valid && in_ready, and transfer as out_valid && out_ready.
REQ-023 SHALL define hazard(X) = out_valid && !bubble && registered word is a load (MD=2'b01, RW=1) && ((uses_a(X) && X.AA==reg.DA) || (uses_b(X) && X.BA==reg.DA)).
REQ-024 SHALL, on accept without hazard, register the decode of X one cycle later (latency 1) and go to FULL.
REQ-025 SHALL, on accept with hazard, register the NOP with bubble=1, latch X into the hold register, increment bubble_cnt and go to HOLD.
REQ-026 SHALL, in HOLD, on transfer, register the decode of the held instruction with bubble=0 and go to FULL.
REQ-027 SHALL, in FULL on transfer without accept, go to EMPTY; transfer and accept in the same cycle is legal (full throughput).
REQ-028 SHALL hold the registered word and out_valid stable while out_valid && !out_ready.
REQ-029 SHALL saturate bubble_cnt at all-ones; it is never wrapped.
REQ-030 SHALL, when flush=1, go to EMPTY next cycle, set out_valid=0 and drop the held instruction; no accept occurs that cycle and flush wins over any simultaneous event; bubble_cnt is unaffected.

Reset
REQ-031 SHALL, when rst_n=0 at a clock edge, set state=EMPTY, out_valid=0, all controls to NOP values, illegal=0, bubble=0, bubble_cnt=0 and clear the hold register; reset overrides flush and all handshakes, including mid-HOLD.

Structure
REQ-032 SHALL place the following in shared package decode_pkg: opcode constants, the NOP control constant, the packed control-word typedef, and the per-opcode uses_a/uses_b flags (uses_b set only for ADD, SUB, SLT, XOR, JR, IN, OUT).
REQ-033 SHALL use one combinational sub-module, instr_decode_comb (instruction in, control word plus illegal out), instantiated twice: once for instr, once for the hold register.

Verification
REQ-034 SHALL cover ADD: instr=0x01458 with out_ready=1 -> next cycle out_valid=1, RW=1, FS=0000, DA=2, AA=1, BA=3, illegal=0.
REQ-035 SHALL cover load-use: load 0x07840 (DA=4) then ADD 0x01B10 (AA=4) back-to-back -> sequence load, NOP with bubble=1, ADD; bubble_cnt=1; in_ready=0 during HOLD.
REQ-036 SHALL cover illegal opcode: instr=0x10000 -> NOP controls, illegal=1, fpga_wrt=0.
REQ-037 SHALL cover backpressure: out_ready=0 for 5 cycles with FULL -> word stable, in_ready=0; out_ready=1 -> transfer, next instruction accepted the same cycle.
REQ-038 SHALL cover flush: flush in HOLD -> EMPTY next cycle, held ADD never appears, bubble_cnt retained.
REQ-039 SHALL cover reset: rst_n=0 in FULL -> all outputs at reset values after the edge; bubble_cnt is forced to all-ones and shown to saturate on a further hazard.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: opcode map, control-word layout and per-opcode operand usage
package decode_pkg;
    typedef struct packed {
        logic       rw;
        logic       ps;
        logic       mw;
        logic       ma;
        logic       mb;
        logic       cs;
        logic       fpga_wrt;
        logic [1:0] md;
        logic [1:0] bs;
        logic [3:0] fs;
    } ctrl_t;
    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_ANDI = 5'h03;
    localparam logic [4:0] OP_ORI  = 5'h04;
    localparam logic [4:0] OP_XOR  = 5'h05;
    localparam logic [4:0] OP_NOT  = 5'h06;
    localparam logic [4:0] OP_LD   = 5'h07;
    localparam logic [4:0] OP_ST   = 5'h08;
    localparam logic [4:0] OP_SLT  = 5'h09;
    localparam logic [4:0] OP_SHL  = 5'h0A;
    localparam logic [4:0] OP_SHR  = 5'h0B;
    localparam logic [4:0] OP_LDI  = 5'h0C;
    localparam logic [4:0] OP_ADI  = 5'h0D;
    localparam logic [4:0] OP_BZ   = 5'h0E;
    localparam logic [4:0] OP_BNZ  = 5'h0F;
    localparam logic [4:0] OP_JMP  = 5'h11;
    localparam logic [4:0] OP_JR   = 5'h12;
    localparam logic [4:0] OP_IN   = 5'h13;
    localparam logic [4:0] OP_OUT  = 5'h14;
    localparam logic [4:0] OP_LDA  = 5'h15;
    localparam ctrl_t NOP_CTRL = '{fs: 4'b1001, default: '0};
    // 0x10 is a hole in the map; everything above 0x15 is undefined
    localparam logic [31:0] LEGAL_OPS = 32'h003E_FFFF;
    localparam logic [31:0] USES_A = (32'd1 << OP_ADD) | (32'd1 << OP_SUB) | (32'd1 << OP_ANDI) |
        (32'd1 << OP_ORI) | (32'd1 << OP_XOR) | (32'd1 << OP_NOT) | (32'd1 << OP_LD) |
        (32'd1 << OP_ST) | (32'd1 << OP_SLT) | (32'd1 << OP_SHL) | (32'd1 << OP_SHR) |
        (32'd1 << OP_ADI) | (32'd1 << OP_BZ) | (32'd1 << OP_BNZ) | (32'd1 << OP_IN) |
        (32'd1 << OP_OUT);
    localparam logic [31:0] USES_B = (32'd1 << OP_ADD) | (32'd1 << OP_SUB) | (32'd1 << OP_SLT) |
        (32'd1 << OP_XOR) | (32'd1 << OP_JR) | (32'd1 << OP_IN) | (32'd1 << OP_OUT);
    function automatic ctrl_t decode_op(input logic [4:0] op);
        ctrl_t c;
        c = NOP_CTRL;
        case (op)
            OP_ADD:  begin c.rw = 1'b1; c.fs = 4'b0000; end
            OP_SUB:  begin c.rw = 1'b1; c.fs = 4'b0001; end
            OP_ANDI: begin c.rw = 1'b1; c.mb = 1'b1; c.fs = 4'b0010; end
            OP_ORI:  begin c.rw = 1'b1; c.mb = 1'b1; c.fs = 4'b0011; end
            OP_XOR:  begin c.rw = 1'b1; c.fs = 4'b0100; end
            OP_NOT:  begin c.rw = 1'b1; c.fs = 4'b0101; end
            OP_LD:   begin c.rw = 1'b1; c.md = 2'b01; end
            OP_ST:   c.mw = 1'b1;
            OP_SLT:  begin c.rw = 1'b1; c.fs = 4'b0110; end
            OP_SHL:  begin c.rw = 1'b1; c.fs = 4'b0111; end
            OP_SHR:  begin c.rw = 1'b1; c.fs = 4'b1000; end
            OP_LDI:  begin c.rw = 1'b1; c.mb = 1'b1; end
            OP_ADI:  begin c.rw = 1'b1; c.mb = 1'b1; c.cs = 1'b1; c.fs = 4'b0000; end
            OP_BZ:   c.bs = 2'b01;
            OP_BNZ:  begin c.bs = 2'b01; c.ps = 1'b1; end
            OP_JMP:  begin c.bs = 2'b11; c.mb = 1'b1; end
            OP_JR:   c.bs = 2'b10;
            OP_IN:   begin c.rw = 1'b1; c.md = 2'b10; end
            OP_OUT:  c.fpga_wrt = 1'b1;
            OP_LDA:  begin c.rw = 1'b1; c.md = 2'b01; c.ma = 1'b1; end
            default: c = NOP_CTRL;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/instr_decode_comb.sv
// instr_decode_comb: purely combinational instruction-to-control-word decoder
module instr_decode_comb
    import decode_pkg::*;
#(
    parameter int INSTR_W = 17,
    parameter int OP_W    = 5,
    parameter int REG_W   = 3
) (
    input  logic [INSTR_W-1:0] instr,
    output ctrl_t              ctrl,
    output logic [REG_W-1:0]   da,
    output logic [REG_W-1:0]   aa,
    output logic [REG_W-1:0]   ba,
    output logic               illegal,
    output logic               uses_a,
    output logic               uses_b
);
    logic [OP_W-1:0] op;
    logic [4:0]      op5;
    logic            legal;
    logic            regs_on;
    assign op      = instr[INSTR_W-1 -: OP_W];
    assign op5     = op[4:0];
    assign legal   = ((op >> 5) == '0) && LEGAL_OPS[op5];
    assign regs_on = legal && (op5 != OP_NOP);
    assign illegal = !legal;
    assign ctrl    = legal ? decode_op(op5) : NOP_CTRL;
    assign da      = regs_on ? instr[INSTR_W-OP_W-1 -: REG_W] : '0;
    assign aa      = regs_on ? instr[INSTR_W-OP_W-REG_W-1 -: REG_W] : '0;
    assign ba      = regs_on ? instr[INSTR_W-OP_W-2*REG_W-1 -: REG_W] : '0;
    assign uses_a  = legal && USES_A[op5];
    assign uses_b  = legal && USES_B[op5];
    if (INSTR_W > OP_W + 3*REG_W) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^instr[INSTR_W-OP_W-3*REG_W-1:0];
    end
endmodule

// File: rtl/instr_decode_pipe.sv
// instr_decode_pipe: registered decode stage with load-use interlock and bubble insertion
module instr_decode_pipe
    import decode_pkg::*;
#(
    parameter int INSTR_W = 17,
    parameter int OP_W    = 5,
    parameter int REG_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               RW,
    output logic               PS,
    output logic               MW,
    output logic               MA,
    output logic               MB,
    output logic               CS,
    output logic               fpga_wrt,
    output logic [1:0]         MD,
    output logic [1:0]         BS,
    output logic [3:0]         FS,
    output logic [REG_W-1:0]   DA,
    output logic [REG_W-1:0]   AA,
    output logic [REG_W-1:0]   BA,
    output logic               illegal,
    output logic               bubble,
    output logic [CNT_W-1:0]   bubble_cnt
);
    typedef enum logic [1:0] {EMPTY, FULL, HOLD} state_t;
    state_t state, state_nxt;
    logic [INSTR_W-1:0] hold_q;
    ctrl_t ctrl_q, in_ctrl, hold_ctrl, nxt_ctrl;
    logic [REG_W-1:0] in_da, in_aa, in_ba, hold_da, hold_aa, hold_ba;
    logic [REG_W-1:0] nxt_da, nxt_aa, nxt_ba;
    logic in_ill, hold_ill, nxt_ill, in_ua, in_ub;
    logic unused_hold_ua, unused_hold_ub;
    logic accept, transfer, hazard, load_new, load_bubble, load_held;
    instr_decode_comb #(.INSTR_W(INSTR_W), .OP_W(OP_W), .REG_W(REG_W)) u_dec_in (
        .instr(instr), .ctrl(in_ctrl), .da(in_da), .aa(in_aa), .ba(in_ba),
        .illegal(in_ill), .uses_a(in_ua), .uses_b(in_ub)
    );
    instr_decode_comb #(.INSTR_W(INSTR_W), .OP_W(OP_W), .REG_W(REG_W)) u_dec_hold (
        .instr(hold_q), .ctrl(hold_ctrl), .da(hold_da), .aa(hold_aa), .ba(hold_ba),
        .illegal(hold_ill), .uses_a(unused_hold_ua), .uses_b(unused_hold_ub)
    );
    assign out_valid = state != EMPTY;
    assign in_ready  = !flush && state != HOLD && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;
    // only a load sitting in the output register can stall the next instruction
    assign hazard = out_valid && !bubble && ctrl_q.rw && ctrl_q.md == 2'b01 &&
                    ((in_ua && in_aa == DA) || (in_ub && in_ba == DA));
    assign {RW, PS, MW, MA, MB, CS, fpga_wrt, MD, BS, FS} = ctrl_q;
    always_comb begin
        state_nxt   = state;
        load_new    = 1'b0;
        load_bubble = 1'b0;
        load_held   = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else if (state == HOLD) begin
            load_held = transfer;
            state_nxt = transfer ? FULL : HOLD;
        end else if (accept) begin
            load_bubble = hazard;
            load_new    = !hazard;
            state_nxt   = hazard ? HOLD : FULL;
        end else if (transfer) begin
            state_nxt = EMPTY;
        end
    end
    assign nxt_ctrl = load_held ? hold_ctrl : load_new ? in_ctrl : NOP_CTRL;
    assign nxt_da   = load_held ? hold_da : load_new ? in_da : '0;
    assign nxt_aa   = load_held ? hold_aa : load_new ? in_aa : '0;
    assign nxt_ba   = load_held ? hold_ba : load_new ? in_ba : '0;
    assign nxt_ill  = load_held ? hold_ill : load_new ? in_ill : 1'b0;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q     <= NOP_CTRL;
            DA         <= '0;
            AA         <= '0;
            BA         <= '0;
            illegal    <= 1'b0;
            bubble     <= 1'b0;
            bubble_cnt <= '0;
            hold_q     <= '0;
        end else begin
            if (flush)            hold_q <= '0;
            else if (load_bubble) hold_q <= instr;
            if (load_new || load_held || load_bubble) begin
                ctrl_q  <= nxt_ctrl;
                DA      <= nxt_da;
                AA      <= nxt_aa;
                BA      <= nxt_ba;
                illegal <= nxt_ill;
                bubble  <= load_bubble;
            end
            if (load_bubble && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb_instr_decode_pipe: randomized scoreboard bench for the decode stage
module tb_instr_decode_pipe;
    localparam int CNT_W = 4;
    localparam logic [14:0] NOP_C = 15'h0009;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [16:0] instr = '0;
    logic in_ready, out_valid, RW, PS, MW, MA, MB, CS, fpga_wrt, illegal, bubble;
    logic [1:0] MD, BS;
    logic [3:0] FS;
    logic [2:0] DA, AA, BA;
    logic [CNT_W-1:0] bubble_cnt;
    logic [25:0] exp_q[$];
    int compared = 0, mismatched = 0;
    int occ = 0, cnt_m = 0, pre;
    logic last_load = 1'b0, acc, hz;
    logic [2:0] last_da = '0;
    logic [4:0] m_op;
    logic [25:0] m_w;
    wire [25:0] act_word = {RW, PS, MW, MA, MB, CS, fpga_wrt, MD, BS, FS, DA, AA, BA, illegal, bubble};
    always #5 clk = ~clk;
    instr_decode_pipe #(.INSTR_W(17), .OP_W(5), .REG_W(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .RW(RW), .PS(PS),
        .MW(MW), .MA(MA), .MB(MB), .CS(CS), .fpga_wrt(fpga_wrt), .MD(MD), .BS(BS), .FS(FS),
        .DA(DA), .AA(AA), .BA(BA), .illegal(illegal), .bubble(bubble), .bubble_cnt(bubble_cnt)
    );
    function automatic logic [14:0] mk(input bit rw, ps, mw, ma, mb, cs, fw,
                                       input logic [1:0] md, bs, input logic [3:0] fs);
        return {rw, ps, mw, ma, mb, cs, fw, md, bs, fs};
    endfunction
    // ISA table: one row per opcode, fields rw ps mw ma mb cs fpga_wrt md bs fs
    function automatic logic [25:0] ref_word(input logic [16:0] ins);
        logic [14:0] c;
        logic [4:0] op;
        op = ins[16:12];
        case (op)
            5'h01: c = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            5'h02: c = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            5'h03: c = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 2);
            5'h04: c = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 3);
            5'h05: c = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
            5'h06: c = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5);
            5'h07: c = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 9);
            5'h08: c = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 9);
            5'h09: c = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6);
            5'h0A: c = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7);
            5'h0B: c = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 8);
            5'h0C: c = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 9);
            5'h0D: c = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
            5'h0E: c = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
            5'h0F: c = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 9);
            5'h11: c = mk(0, 0, 0, 0, 1, 0, 0, 0, 3, 9);
            5'h12: c = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 9);
            5'h13: c = mk(1, 0, 0, 0, 0, 0, 0, 2, 0, 9);
            5'h14: c = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 9);
            5'h15: c = mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 9);
            default: c = NOP_C;
        endcase
        if (op == 5'h10 || op > 5'h15) return {NOP_C, 9'd0, 1'b1, 1'b0};
        if (op == 5'h00) return {NOP_C, 11'd0};
        return {c, ins[11:3], 2'b00};
    endfunction
    function automatic bit ua(input logic [4:0] op);
        return op inside {1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 14, 15, 19, 20};
    endfunction
    function automatic bit ub(input logic [4:0] op);
        return op inside {1, 2, 5, 9, 18, 19, 20};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic drive(input logic v, input logic [16:0] ins, input logic r, input logic f);
        in_valid = v; instr = ins; out_ready = r; flush = f;
        @(posedge clk); #1;
    endtask
    // reference model: counts outstanding words and queues what must come out
    always @(posedge clk) begin
        if (!rst_n) begin
            occ = 0; cnt_m = 0; last_load = 1'b0; last_da = '0;
            exp_q.delete();
        end else if (flush) begin
            occ = 0;
            exp_q.delete();
        end else begin
            pre = occ;
            acc = in_valid && pre < 2 && (pre == 0 || out_ready);
            if (pre > 0 && out_ready) occ--;
            if (acc) begin
                m_op = instr[16:12];
                m_w  = ref_word(instr);
                hz = pre == 1 && last_load &&
                     ((ua(m_op) && instr[8:6] == last_da) || (ub(m_op) && instr[5:3] == last_da));
                if (hz) begin
                    exp_q.push_back({NOP_C, 9'd0, 1'b0, 1'b1});
                    cnt_m = cnt_m < 15 ? cnt_m + 1 : 15;
                    occ++;
                end
                exp_q.push_back(m_w);
                occ++;
                last_load = m_w[25] && m_w[18:17] == 2'b01;
                last_da = m_w[10:8];
            end
        end
    end
    // monitor: checks handshake view every cycle and pops on each transfer
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(occ > 0));
            chk("in_ready", 32'(in_ready), 32'(!flush && occ < 2 && (occ == 0 || out_ready)));
            chk("bubble_cnt", 32'(bubble_cnt), cnt_m);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL word: got %h, expected no valid word (t=%0t)", act_word, $time);
                end else begin
                    chk("word", 32'(act_word), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end
    function automatic logic [16:0] rnd_instr();
        logic [4:0] op;
        op = ($urandom_range(0, 2) == 0) ? 5'h07 : 5'($urandom_range(0, 31));
        return {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                3'($urandom_range(0, 3)), 3'($urandom)};
    endfunction
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_word"}, 32'(act_word), 32'({NOP_C, 11'd0}));
        chk({tag, "_cnt"}, 32'(bubble_cnt), 0);
    endtask
    initial begin
        drive(0, '0, 0, 0);
        drive(0, '0, 0, 0);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        drive(1, 17'h01458, 1, 0);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_rw", 32'(RW), 1);
        chk("add_fs", 32'(FS), 0);
        chk("add_regs", 32'({DA, AA, BA}), 32'({3'd2, 3'd1, 3'd3}));
        chk("add_illegal", 32'(illegal), 0);
        drive(0, '0, 1, 0);
        drive(1, 17'h07840, 1, 0);
        drive(1, 17'h01B10, 1, 0);
        chk("hold_bubble", 32'(bubble), 1);
        chk("hold_in_ready", 32'(in_ready), 0);
        drive(0, '0, 1, 0);
        chk("held_add_da", 32'(DA), 5);
        drive(0, '0, 1, 0);
        chk("loaduse_cnt", 32'(bubble_cnt), 1);
        drive(1, 17'h10000, 1, 0);
        chk("illegal_flag", 32'(illegal), 1);
        chk("illegal_fpga", 32'(fpga_wrt), 0);
        chk("illegal_fs", 32'(FS), 9);
        drive(0, '0, 1, 0);
        drive(1, 17'h01458, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, 17'h02000, 0, 0);
        chk("bp_word", 32'({RW, FS, DA}), 32'({1'b1, 4'd0, 3'd2}));
        drive(1, 17'h02000, 1, 0);
        chk("bp_next_fs", 32'(FS), 1);
        drive(0, '0, 1, 0);
        drive(1, 17'h07840, 1, 0);
        drive(1, 17'h01B10, 1, 0);
        drive(0, '0, 0, 1);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_cnt", 32'(bubble_cnt), 2);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        for (int i = 0; i < 2000; i++)
            drive($urandom_range(0, 9) < 7, rnd_instr(), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 3);
        for (int i = 0; i < 3; i++) drive(0, '0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 17'h07200, 1, 0);
            drive(1, 17'h01040, 1, 0);
            drive(0, '0, 1, 0);
            drive(0, '0, 1, 0);
        end
        chk("cnt_saturated", 32'(bubble_cnt), 15);
        drive(1, 17'h07200, 1, 0);
        drive(1, 17'h01040, 1, 0);
        chk("cnt_still_sat", 32'(bubble_cnt), 15);
        chk("sat_bubble", 32'(bubble), 1);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        drive(1, 17'h01458, 1, 0);
        rst_n = 1'b0;
        drive(1, 17'h07840, 1, 1);
        chk_reset_vals("reset_full");
        rst_n = 1'b1;
        drive(0, '0, 1, 0);
        drive(1, 17'h07200, 1, 0);
        drive(1, 17'h01040, 1, 0);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        chk("post_reset_cnt", 32'(bubble_cnt), 1);
        drive(0, '0, 1, 0);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
